// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the 8080-style LCD write-bus receiver:
// command codes, decoder state encoding and the internal coordinate type.
package lcd_bus_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CASET_P,
      ST_PASET_P,
      ST_RAMWR
   } lcd_state_t;

   typedef logic [15:0] coord_t;

endpackage

// File: rtl/lcd_bus_rx_if.sv
// LCD 8080-style write bus as seen between the DMA controller (master)
// and the panel model (slave).
interface lcd_bus_rx_if;
   logic        lcd_d_c_n;
   logic        lcd_wr_n;
   logic [15:0] lcd_data;

   modport master (output lcd_d_c_n, output lcd_wr_n, output lcd_data);
   modport slave  (input  lcd_d_c_n, input  lcd_wr_n, input  lcd_data);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous {wr_n, d_c_n, data} bundle into clk and
// emits a registered one-cycle write event on the synchronized wr_n rise.
module lcd_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_n,
   input  logic        d_c_n,
   input  logic [15:0] data,
   output logic        ev_valid,
   output logic        ev_d_c_n,
   output logic [15:0] ev_data
);

   // wr_n idles high so a reset never manufactures a rising edge
   localparam logic [17:0] BUNDLE_RST = 18'h2_0000;

   logic [17:0] stg [SYNC_STAGES];
   logic        wr_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= BUNDLE_RST;
         wr_last  <= 1'b1;
         ev_valid <= 1'b0;
         ev_d_c_n <= 1'b0;
         ev_data  <= 16'h0000;
      end else begin
         stg[0] <= {wr_n, d_c_n, data};
         for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
         wr_last  <= stg[SYNC_STAGES-1][17];
         ev_valid <= stg[SYNC_STAGES-1][17] & ~wr_last;
         ev_d_c_n <= stg[SYNC_STAGES-1][16];
         ev_data  <= stg[SYNC_STAGES-1][15:0];
      end
   end

endmodule

// File: rtl/lcd_bus_rx.sv
// ILI9341-subset command decoder: window registers (CASET/PASET) and an
// addressed RAMWR pixel stream. LCD_BUS_RX_STATS_EN adds pix_count/frame_done.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no active command; data writes are errors
// ST_CASET_P | collecting 4 column-window parameter bytes
// ST_PASET_P | collecting 4 page-window parameter bytes
// ST_RAMWR   | each data write is a pixel at (x,y)
module lcd_bus_rx
   import lcd_bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int COORD_W     = 9,
   parameter int COL_MAX     = 239,
   parameter int PAGE_MAX    = 319
) (
   input  logic               clk,
   input  logic               reset,
   lcd_bus_rx_if.slave        bus,
   output logic               pix_valid,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [15:0]        pix_data,
   output logic               cmd_valid,
   output logic [7:0]         cmd_code,
`ifdef LCD_BUS_RX_STATS_EN
   output logic [31:0]        pix_count,
   output logic               frame_done,
`endif
   output logic               proto_err
);

   localparam coord_t EC_RST = 16'(COL_MAX);
   localparam coord_t EP_RST = 16'(PAGE_MAX);

   logic        ev_valid;
   logic        ev_d_c_n;
   logic [15:0] ev_data;

   lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .wr_n     (bus.lcd_wr_n),
      .d_c_n    (bus.lcd_d_c_n),
      .data     (bus.lcd_data),
      .ev_valid (ev_valid),
      .ev_d_c_n (ev_d_c_n),
      .ev_data  (ev_data)
   );

   lcd_state_t state, state_n;
   logic [1:0] pcnt, pcnt_n;
   coord_t     sh_start, sh_start_n;
   logic [7:0] sh_end_hi, sh_end_hi_n;
   coord_t     sc, sc_n, ec, ec_n, sp, sp_n, ep, ep_n;
   coord_t     x, x_n, y, y_n;
   coord_t     end_cat;

   logic               pix_valid_n;
   logic [COORD_W-1:0] pix_x_n, pix_y_n;
   logic [15:0]        pix_data_n;
   logic               cmd_valid_n;
   logic [7:0]         cmd_code_n;
   logic               proto_err_n;
`ifdef LCD_BUS_RX_STATS_EN
   logic [31:0]        pix_count_n;
   logic               frame_done_n;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         pcnt      <= 2'd0;
         sh_start  <= '0;
         sh_end_hi <= 8'h00;
         sc        <= '0;
         ec        <= EC_RST;
         sp        <= '0;
         ep        <= EP_RST;
         x         <= '0;
         y         <= '0;
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_data  <= 16'h0000;
         cmd_valid <= 1'b0;
         cmd_code  <= 8'h00;
         proto_err <= 1'b0;
`ifdef LCD_BUS_RX_STATS_EN
         pix_count  <= 32'd0;
         frame_done <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         pcnt      <= pcnt_n;
         sh_start  <= sh_start_n;
         sh_end_hi <= sh_end_hi_n;
         sc        <= sc_n;
         ec        <= ec_n;
         sp        <= sp_n;
         ep        <= ep_n;
         x         <= x_n;
         y         <= y_n;
         pix_valid <= pix_valid_n;
         pix_x     <= pix_x_n;
         pix_y     <= pix_y_n;
         pix_data  <= pix_data_n;
         cmd_valid <= cmd_valid_n;
         cmd_code  <= cmd_code_n;
         proto_err <= proto_err_n;
`ifdef LCD_BUS_RX_STATS_EN
         pix_count  <= pix_count_n;
         frame_done <= frame_done_n;
`endif
      end
   end

   always_comb begin
      state_n     = state;
      pcnt_n      = pcnt;
      sh_start_n  = sh_start;
      sh_end_hi_n = sh_end_hi;
      sc_n        = sc;
      ec_n        = ec;
      sp_n        = sp;
      ep_n        = ep;
      x_n         = x;
      y_n         = y;
      end_cat     = {sh_end_hi, ev_data[7:0]};
      pix_valid_n = 1'b0;
      pix_x_n     = pix_x;
      pix_y_n     = pix_y;
      pix_data_n  = pix_data;
      cmd_valid_n = 1'b0;
      cmd_code_n  = cmd_code;
      proto_err_n = 1'b0;
`ifdef LCD_BUS_RX_STATS_EN
      pix_count_n  = pix_count;
      frame_done_n = 1'b0;
`endif

      if (ev_valid) begin
         if (!ev_d_c_n) begin
            // a command always wins, abandoning any partial parameter set
            cmd_valid_n = 1'b1;
            cmd_code_n  = ev_data[7:0];
            pcnt_n      = 2'd0;
            case (ev_data[7:0])
               CMD_CASET: state_n = ST_CASET_P;
               CMD_PASET: state_n = ST_PASET_P;
               CMD_RAMWR: begin
                  state_n = ST_RAMWR;
                  x_n     = sc;
                  y_n     = sp;
`ifdef LCD_BUS_RX_STATS_EN
                  pix_count_n = 32'd0;
`endif
               end
               default:   state_n = ST_IDLE;
            endcase
         end else begin
            case (state)
               ST_IDLE: proto_err_n = 1'b1;
               ST_CASET_P, ST_PASET_P: begin
                  pcnt_n = pcnt + 2'd1;
                  case (pcnt)
                     2'd0: sh_start_n[15:8] = ev_data[7:0];
                     2'd1: sh_start_n[7:0]  = ev_data[7:0];
                     2'd2: sh_end_hi_n      = ev_data[7:0];
                     default: begin
                        state_n = ST_IDLE;
                        if (sh_start > end_cat) begin
                           proto_err_n = 1'b1;
                        end else if (state == ST_CASET_P) begin
                           sc_n = sh_start;
                           ec_n = end_cat;
                        end else begin
                           sp_n = sh_start;
                           ep_n = end_cat;
                        end
                     end
                  endcase
               end
               default: begin
                  pix_valid_n = 1'b1;
                  pix_x_n     = x[COORD_W-1:0];
                  pix_y_n     = y[COORD_W-1:0];
                  pix_data_n  = ev_data;
`ifdef LCD_BUS_RX_STATS_EN
                  if (pix_count != 32'hFFFF_FFFF) pix_count_n = pix_count + 32'd1;
                  frame_done_n = (x == ec) && (y == ep);
`endif
                  if (x == ec) begin
                     x_n = sc;
                     y_n = (y == ep) ? sp : y + 16'd1;
                  end else begin
                     x_n = x + 16'd1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Scoreboard bench for lcd_bus_rx: tasks push expected output events,
// a monitor pops and compares them as the DUT pulses its outputs.
module tb_lcd_bus_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_valid, cmd_valid, proto_err;
   logic [8:0]  pix_x, pix_y;
   logic [15:0] pix_data;
   logic [7:0]  cmd_code;
`ifdef LCD_BUS_RX_STATS_EN
   logic [31:0] pix_count;
   logic        frame_done;
`endif

   lcd_bus_rx_if bus();

   lcd_bus_rx #(.SYNC_STAGES(2), .COORD_W(9), .COL_MAX(239), .PAGE_MAX(319)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .pix_valid (pix_valid),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_data  (pix_data),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
`ifdef LCD_BUS_RX_STATS_EN
      .pix_count (pix_count),
      .frame_done(frame_done),
`endif
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   // kind is the expected one-hot {pix_valid, cmd_valid, proto_err}
   typedef struct {
      logic [2:0]  kind;
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
      logic        fd;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   exp_t       e;
   logic [2:0] obs;
   logic       bad;

   always begin
      @(posedge clk);
      #1;
      obs = {pix_valid, cmd_valid, proto_err};
      if (obs !== 3'b000) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got flags %b x=%0d y=%0d d=%h code=%h, want no event",
                     obs, pix_x, pix_y, pix_data, cmd_code);
         end else begin
            e = exp_q.pop_front();
            bad = (obs !== e.kind);
            if (e.kind == 3'b100)
               bad = bad | (pix_x !== e.x) | (pix_y !== e.y) | (pix_data !== e.d);
            if (e.kind == 3'b010)
               bad = bad | (cmd_code !== e.d[7:0]);
`ifdef LCD_BUS_RX_STATS_EN
            if (e.kind == 3'b100)
               bad = bad | (frame_done !== e.fd);
`endif
            if (bad) begin
               miscompares++;
               $display("FAIL event: got flags %b x=%0d y=%0d d=%h code=%h, want flags %b x=%0d y=%0d d=%h",
                        obs, pix_x, pix_y, pix_data, cmd_code, e.kind, e.x, e.y, e.d);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic void push_pix(input int px, input int py, input logic [15:0] d, input logic fd);
      exp_t t;
      t.kind = 3'b100; t.x = 9'(px); t.y = 9'(py); t.d = d; t.fd = fd;
      exp_q.push_back(t);
   endfunction

   function automatic void push_cmd(input logic [7:0] c);
      exp_t t;
      t.kind = 3'b010; t.x = '0; t.y = '0; t.d = {8'h00, c}; t.fd = 1'b0;
      exp_q.push_back(t);
   endfunction

   function automatic void push_err();
      exp_t t;
      t.kind = 3'b001; t.x = '0; t.y = '0; t.d = '0; t.fd = 1'b0;
      exp_q.push_back(t);
   endfunction

   // wr_n low for 4 clocks, high for 4; the output lands 4 clocks after the rise
   task automatic bus_wr(input logic dcn, input logic [15:0] d);
      @(posedge clk); #1;
      bus.lcd_d_c_n = dcn;
      bus.lcd_data  = d;
      bus.lcd_wr_n  = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.lcd_wr_n = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic wr_cmd(input logic [7:0] c);
      push_cmd(c);
      bus_wr(1'b0, {8'h00, c});
   endtask

   task automatic wr_params(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      bus_wr(1'b1, {8'h00, b0});
      bus_wr(1'b1, {8'h00, b1});
      bus_wr(1'b1, {8'h00, b2});
      bus_wr(1'b1, {8'h00, b3});
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      bus.lcd_wr_n = 1'b1; bus.lcd_d_c_n = 1'b1; bus.lcd_data = 16'h0000;
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if ({pix_valid, pix_x, pix_y, pix_data, cmd_valid, cmd_code, proto_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_during: got pv=%b x=%0d y=%0d d=%h cv=%b code=%h err=%b, want all 0",
                  pix_valid, pix_x, pix_y, pix_data, cmd_valid, cmd_code, proto_err);
      end
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if ({pix_valid, pix_x, pix_y, pix_data, cmd_valid, cmd_code, proto_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_after: got pv=%b x=%0d y=%0d d=%h cv=%b code=%h err=%b, want all 0",
                  pix_valid, pix_x, pix_y, pix_data, cmd_valid, cmd_code, proto_err);
      end
   endtask

   task automatic test_basic();
      wr_cmd(8'h2C);
      push_pix(0, 0, 16'hF800, 1'b0); bus_wr(1'b1, 16'hF800);
      push_pix(1, 0, 16'h07E0, 1'b0); bus_wr(1'b1, 16'h07E0);
      push_pix(2, 0, 16'h001F, 1'b0); bus_wr(1'b1, 16'h001F);
      settle();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL basic_drain: %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_latency();
      push_pix(3, 0, 16'h1234, 1'b0);
      @(posedge clk); #1;
      bus.lcd_d_c_n = 1'b1; bus.lcd_data = 16'h1234; bus.lcd_wr_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.lcd_wr_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #2;
         vectors++;
         if (pix_valid !== (i == 4)) begin
            miscompares++;
            $display("FAIL latency_clk%0d: pix_valid=%b, want %b", i, pix_valid, (i == 4));
         end
      end
      settle();
   endtask

   task automatic test_window();
      wr_cmd(8'h2A); wr_params(8'h00, 8'h0A, 8'h00, 8'h0C);
      wr_cmd(8'h2B); wr_params(8'h00, 8'h05, 8'h00, 8'h06);
      wr_cmd(8'h2C);
      push_pix(10, 5, 16'hA000, 1'b0); push_pix(11, 5, 16'hA001, 1'b0);
      push_pix(12, 5, 16'hA002, 1'b0); push_pix(10, 6, 16'hA003, 1'b0);
      push_pix(11, 6, 16'hA004, 1'b0); push_pix(12, 6, 16'hA005, 1'b0);
      push_pix(10, 5, 16'hA006, 1'b0);
      for (int i = 0; i < 7; i++) bus_wr(1'b1, 16'hA000 + 16'(i));
      settle();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL window_drain: %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bad_window();
      wr_cmd(8'h2A);
      push_err();
      wr_params(8'h00, 8'h14, 8'h00, 8'h0A);
      wr_cmd(8'h2C);
      push_pix(10, 5, 16'hB000, 1'b0); bus_wr(1'b1, 16'hB000);
      settle();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL bad_window_drain: %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_abort();
      wr_cmd(8'h2A);
      bus_wr(1'b1, 16'h0000);
      bus_wr(1'b1, 16'h0004);
      wr_cmd(8'h2C);
      push_pix(10, 5, 16'hC000, 1'b0); push_pix(11, 5, 16'hC001, 1'b0);
      push_pix(12, 5, 16'hC002, 1'b0); push_pix(10, 6, 16'hC003, 1'b0);
      for (int i = 0; i < 4; i++) bus_wr(1'b1, 16'hC000 + 16'(i));
      settle();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL abort_drain: %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_idle_data();
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      push_err();
      bus_wr(1'b1, 16'h5555);
      wr_cmd(8'h00);
      push_err();
      bus_wr(1'b1, 16'h6666);
      settle();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL idle_data_drain: %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      wr_cmd(8'h2C);
      for (int i = 0; i < 5; i++) begin
         push_pix(i, 0, 16'hD000 + 16'(i), 1'b0);
         bus_wr(1'b1, 16'hD000 + 16'(i));
      end
      @(posedge clk); #1;
      bus.lcd_d_c_n = 1'b1; bus.lcd_data = 16'hDEAD; bus.lcd_wr_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      vectors++;
      if ({pix_valid, pix_x, pix_y, pix_data, cmd_valid, cmd_code, proto_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: got pv=%b x=%0d y=%0d d=%h cv=%b code=%h err=%b, want all 0",
                  pix_valid, pix_x, pix_y, pix_data, cmd_valid, cmd_code, proto_err);
      end
      #1 bus.lcd_wr_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (6) @(posedge clk);
      wr_cmd(8'h2C);
      push_pix(0, 0, 16'hE000, 1'b0); bus_wr(1'b1, 16'hE000);
      settle();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_mid_drain: %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

`ifdef LCD_BUS_RX_STATS_EN
   // a 10x8 window keeps the frame short while exercising the same wrap point
   task automatic test_stats();
      wr_cmd(8'h2A); wr_params(8'h00, 8'h00, 8'h00, 8'h09);
      wr_cmd(8'h2B); wr_params(8'h00, 8'h00, 8'h00, 8'h07);
      wr_cmd(8'h2C);
      vectors++;
      if (pix_count !== 32'd0) begin
         miscompares++;
         $display("FAIL stats_clear: pix_count=%0d, want 0", pix_count);
      end
      for (int py = 0; py < 8; py++)
         for (int px = 0; px < 10; px++) begin
            push_pix(px, py, 16'(py * 16 + px), (px == 9) && (py == 7));
            bus_wr(1'b1, 16'(py * 16 + px));
         end
      settle();
      vectors++;
      if (pix_count !== 32'd80) begin
         miscompares++;
         $display("FAIL stats_count: pix_count=%0d, want 80", pix_count);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL stats_drain: %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask
`endif

   initial begin
      bus.lcd_wr_n = 1'b1;
      bus.lcd_d_c_n = 1'b1;
      bus.lcd_data = 16'h0000;
      test_reset();
      test_basic();
      test_latency();
      test_window();
      test_bad_window();
      test_abort();
      test_idle_data();
      test_reset_mid();
`ifdef LCD_BUS_RX_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
